// File: rtl/grf_wb_bypass_if.sv
// WB-stage write port, two decode read ports and the commit trace record of the register file.
// master = pipeline side, slave = register file.
interface grf_wb_bypass_if;
    logic        WE;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic [31:0] WPC;
    logic [4:0]  RAddr1;
    logic [4:0]  RAddr2;
    logic [31:0] RData1;
    logic [31:0] RData2;
    logic        TraceValid;
    logic [31:0] TracePC;
    logic [4:0]  TraceAddr;
    logic [31:0] TraceData;
    logic [31:0] CommitCount;

    modport master (
        output WE, WAddr, WData, WPC, RAddr1, RAddr2,
        input  RData1, RData2, TraceValid, TracePC, TraceAddr, TraceData, CommitCount
    );

    modport slave (
        input  WE, WAddr, WData, WPC, RAddr1, RAddr2,
        output RData1, RData2, TraceValid, TracePC, TraceAddr, TraceData, CommitCount
    );
endinterface

// File: rtl/grf_wb_bypass.sv
// 32x32 register file with same-cycle WB->ID bypass; reads are combinational, writes land on the edge.
// Trace record and commit counter are registered (1 cycle); no backpressure, one write accepted every cycle.
module grf_wb_bypass (
    input  logic             clk,
    input  logic             reset,
    grf_wb_bypass_if.slave   bus
);
    logic [31:0] regs [1:31];
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] commit_count;
    logic        commit;

    // Writes to $0 are dropped entirely: no store, no trace, no count.
    assign commit = bus.WE && (bus.WAddr != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            trace_valid  <= 1'b0;
            trace_pc     <= '0;
            trace_addr   <= '0;
            trace_data   <= '0;
            commit_count <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                regs[bus.WAddr] <= bus.WData;
                trace_pc        <= bus.WPC;
                trace_addr      <= bus.WAddr;
                trace_data      <= bus.WData;
                commit_count    <= commit_count + 32'd1;
            end
        end
    end

    // Bypass stays live during reset since it is purely combinational.
    assign bus.RData1 = (bus.RAddr1 == 5'd0)                 ? 32'd0     :
                        (bus.WE && bus.WAddr == bus.RAddr1) ? bus.WData :
                                                               regs[bus.RAddr1];
    assign bus.RData2 = (bus.RAddr2 == 5'd0)                 ? 32'd0     :
                        (bus.WE && bus.WAddr == bus.RAddr2) ? bus.WData :
                                                               regs[bus.RAddr2];

    assign bus.TraceValid  = trace_valid;
    assign bus.TracePC     = trace_pc;
    assign bus.TraceAddr   = trace_addr;
    assign bus.TraceData   = trace_data;
    assign bus.CommitCount = commit_count;
endmodule
